// File: rtl/imem_boot_pkg.sv
// Shared constants and state encoding for the instruction-memory boot controller.
package imem_boot_pkg;
  localparam int DEPTH_DEF = 256;
  localparam int BOFF_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_e;
endpackage

// File: rtl/imem_boot_csum.sv
// Running mod-2^32 sum of loaded words; zero_o flags that the sum plus the
// presented word wraps to zero.
module imem_boot_csum (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [31:0] data_i,
  output logic        zero_o
);
  logic [31:0] acc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (add_i) acc_q <= acc_q + data_i;
  end

  assign zero_o = (acc_q + data_i) == 32'd0;
endmodule

// File: rtl/imem_boot_ctrl.sv
// Owns the imem port: streams a boot image in from the loader while the CPU is
// held in reset, then hands the port to fetch. Option: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic [31:0]      i_fetch_addr,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_rstn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  state_e           state_q;
  logic [LEN_W-1:0] cnt_q, len_q, len_clamp;
  logic             cpu_rstn_q, done_q;
  logic             start_ok, hs, last;

  assign start_ok  = i_start && (state_q == ST_IDLE || state_q == ST_RUN);
  assign len_clamp = (i_load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_load_len;
  assign s_ready   = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign hs        = s_valid && s_ready;
  assign last      = cnt_q == (len_q - LEN_W'(1));

  // Loader owns the port only in LOAD/CHECK, so fetch and loader never collide.
  assign o_mem_we    = hs && (state_q == ST_LOAD);
  assign o_mem_addr  = s_ready ? 32'({cnt_q, {BOFF_W{1'b0}}}) : i_fetch_addr;
  assign o_mem_wdata = s_data;
  assign o_cpu_rstn  = cpu_rstn_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_RELEASE);

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_e AFTER_LAST = ST_CHECK;
  logic csum_ok, err_q;

  imem_boot_csum u_csum (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (start_ok),
    .add_i  (o_mem_we),
    .data_i (s_data),
    .zero_o (csum_ok)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                    err_q <= 1'b0;
    else if (start_ok)                            err_q <= 1'b0;
    else if (state_q == ST_CHECK && hs && !csum_ok) err_q <= 1'b1;
  end
  assign o_err = err_q;
`else
  localparam state_e AFTER_LAST = ST_RELEASE;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      cpu_rstn_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      cpu_rstn_q <= 1'b0;
      if (start_ok) begin
        len_q   <= len_clamp;
        cnt_q   <= '0;
        state_q <= (len_clamp == '0) ? ST_RELEASE : ST_LOAD;
      end else begin
        case (state_q)
          ST_LOAD: if (hs) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last) state_q <= AFTER_LAST;
          end
`ifdef IMEM_BOOT_CHECKSUM_EN
          ST_CHECK: if (hs) state_q <= csum_ok ? ST_RELEASE : ST_IDLE;
`endif
          ST_RELEASE: begin
            done_q  <= 1'b1;
            state_q <= ST_RUN;
          end
          ST_RUN:  cpu_rstn_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl against a write-list / memory-image model.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 256;
  localparam int LEN_W = 9;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic clk = 0, rstn = 0, i_start = 0, s_valid = 0;
  logic [LEN_W-1:0] i_load_len = '0;
  logic [31:0] s_data = '0, i_fetch_addr = '0;
  logic s_ready, o_mem_we, o_cpu_rstn, o_busy, o_done, o_err;
  logic [31:0] o_mem_addr, o_mem_wdata;

  imem_boot_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_load_len(i_load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .i_fetch_addr(i_fetch_addr), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_cpu_rstn(o_cpu_rstn), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = -1, rise_cyc = -1, bad_we = 0;
  logic prev_rstn_o = 0;
  logic [31:0] wq_addr[$], wq_data[$];
  int wq_cyc[$];
  logic [31:0] imem[DEPTH];     // image the DUT actually wrote
  logic [31:0] ref_mem[DEPTH];  // image the model expects
  logic [31:0] wbuf[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the memory port mid-cycle and build the written image.
  always @(negedge clk) begin
    #2;
    if (o_mem_we) begin
      wq_addr.push_back(o_mem_addr);
      wq_data.push_back(o_mem_wdata);
      wq_cyc.push_back(cyc);
      if (!s_valid) bad_we++;
      if (o_mem_addr < 32'(DEPTH * 4)) imem[o_mem_addr[9:2]] = o_mem_wdata;
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_cpu_rstn && !prev_rstn_o) rise_cyc = cyc;
    prev_rstn_o = o_cpu_rstn;
  end

  function automatic int wq_diffs(input int n);
    int bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (i >= n || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== wbuf[i]) bad++;
    return bad;
  endfunction

  function automatic int mem_diffs();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (imem[i] !== ref_mem[i]) bad++;
    return bad;
  endfunction

  task automatic model_commit(input int n);
    for (int i = 0; i < n; i++) ref_mem[i] = wbuf[i];
  endtask

  task automatic clr_log();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); bad_we = 0;
  endtask

  task automatic gen_words(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  task automatic start(input int len);
    @(negedge clk); i_start = 1; i_load_len = 9'(len); start_cyc = cyc;
    @(negedge clk); i_start = 0;
  endtask

  // cs: 0 no checksum word, 1 correct checksum, 2 checksum word of zero
  task automatic stream(input int n, input int gmin, input int gmax, input bit poke, input int cs);
    int i = 0, gap = 0, bud = 0, tot;
    logic [31:0] acc = 0;
    tot = n + ((CSUM != 0 && cs != 0 && n > 0) ? 1 : 0);
    while (i < tot && bud < 3000) begin
      i_start = 0;
      if (gap > 0) begin
        s_valid = 0; s_data = $urandom; gap--;
        if (poke && $urandom_range(0, 2) == 0) begin i_start = 1; i_load_len = 9'($urandom); end
      end else begin
        s_valid = 1;
        s_data = (i < n) ? wbuf[i] : ((cs == 2) ? 32'd0 : 32'd0 - acc);
      end
      #1;
      if (s_valid && s_ready) begin
        if (i < n) acc += wbuf[i];
        i++; gap = $urandom_range(gmin, gmax);
      end
      @(negedge clk); bud++;
    end
    s_valid = 0; i_start = 0;
    n_chk++; if (i != tot) $display("FAIL stream_handshakes got %0d exp %0d", i, tot); else n_pass++;
  endtask

  task automatic wait_done(input int d0);
    repeat (40) begin
      if (done_cnt != d0) break;
      @(negedge clk); #3;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) begin imem[i] = 0; ref_mem[i] = 0; end
    i_fetch_addr = $urandom;
    repeat (3) @(negedge clk);
    rstn = 1; #1;
    n_chk++;
    if ({s_ready, o_mem_we, o_busy, o_cpu_rstn, o_done, o_err} !== 6'b0)
      $display("FAIL reset_outputs got %b exp 000000", {s_ready, o_mem_we, o_busy, o_cpu_rstn, o_done, o_err});
    else n_pass++;
    n_chk++; if (o_mem_addr !== i_fetch_addr) $display("FAIL reset_fetch_mux got %h exp %h", o_mem_addr, i_fetch_addr); else n_pass++;
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    clr_log();
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333;
    start(3);
    stream(3, 0, 0, 0, 1);
    wait_done(d0);
    repeat (2) @(negedge clk);
    model_commit(3);
    n_chk++; if (wq_addr.size() != 3 || wq_diffs(3) != 0) $display("FAIL basic_writes got %0d writes/%0d bad exp 3/0", wq_addr.size(), wq_diffs(3)); else n_pass++;
    n_chk++; if (wq_cyc.size() != 3 || wq_cyc[0] != start_cyc + 1 || wq_cyc[2] != start_cyc + 3)
      $display("FAIL basic_write_timing got %p exp start %0d +1..+3", wq_cyc, start_cyc); else n_pass++;
    n_chk++; if (done_cnt != d0 + 1 || done_cyc != start_cyc + 5 + CSUM)
      $display("FAIL basic_done got cnt %0d cyc %0d exp cnt %0d cyc %0d", done_cnt - d0, done_cyc, 1, start_cyc + 5 + CSUM); else n_pass++;
    n_chk++; if (rise_cyc != done_cyc + 1 || o_cpu_rstn !== 1'b1)
      $display("FAIL basic_cpu_release got rise %0d exp %0d", rise_cyc, done_cyc + 1); else n_pass++;
    i_fetch_addr = 32'h40; #1;
    n_chk++; if (o_mem_addr !== 32'h40 || o_mem_we !== 1'b0) $display("FAIL basic_fetch_mux got %h exp 00000040", o_mem_addr); else n_pass++;
  endtask

  task automatic test_reload();
    int d0 = done_cnt;
    clr_log();
    gen_words(1);
    start(1); #1;
    n_chk++; if (o_cpu_rstn !== 1'b0) $display("FAIL reload_cpu_hold got %b exp 0", o_cpu_rstn); else n_pass++;
    @(negedge clk);
    stream(1, 0, 2, 0, 1);
    wait_done(d0);
    repeat (2) @(negedge clk);
    model_commit(1);
    n_chk++; if (wq_addr.size() != 1 || wq_diffs(1) != 0) $display("FAIL reload_writes got %0d exp 1", wq_addr.size()); else n_pass++;
    n_chk++; if (mem_diffs() != 0) $display("FAIL reload_mem_retain got %0d diffs exp 0", mem_diffs()); else n_pass++;
    n_chk++; if (done_cnt != d0 + 1 || o_cpu_rstn !== 1'b1) $display("FAIL reload_release got done %0d rstn %b exp 1 1", done_cnt - d0, o_cpu_rstn); else n_pass++;
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    clr_log();
    gen_words(2);
    start(2);
    stream(2, 5, 5, 0, 1);
    wait_done(d0);
    model_commit(2);
    n_chk++; if (wq_addr.size() != 2 || wq_diffs(2) != 0) $display("FAIL bp_writes got %0d exp 2", wq_addr.size()); else n_pass++;
    n_chk++; if (wq_cyc.size() != 2 || wq_cyc[1] - wq_cyc[0] != 6 || bad_we != 0)
      $display("FAIL bp_gap got %p bad_we %0d exp spacing 6", wq_cyc, bad_we); else n_pass++;
    n_chk++; if (done_cnt != d0 + 1) $display("FAIL bp_done got %0d exp 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int d0 = done_cnt, n = $urandom_range(1, 24);
      clr_log();
      gen_words(n);
      i_fetch_addr = $urandom;
      start(n);
      stream(n, 0, 3, 1, 1);
      wait_done(d0);
      repeat (2) @(negedge clk);
      model_commit(n);
      n_chk++; if (wq_addr.size() != n || wq_diffs(n) != 0 || bad_we != 0)
        $display("FAIL rand%0d_writes got %0d/%0d bad exp %0d/0", it, wq_addr.size(), wq_diffs(n), n); else n_pass++;
      n_chk++; if (mem_diffs() != 0 || done_cnt != d0 + 1 || o_cpu_rstn !== 1'b1)
        $display("FAIL rand%0d_image got diffs %0d done %0d exp 0 1", it, mem_diffs(), done_cnt - d0); else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    clr_log();
    start(0);
    wait_done(d0);
    repeat (2) @(negedge clk);
    n_chk++; if (wq_addr.size() != 0) $display("FAIL zero_writes got %0d exp 0", wq_addr.size()); else n_pass++;
    n_chk++; if (done_cnt != d0 + 1 || done_cyc != start_cyc + 2)
      $display("FAIL zero_done got cyc %0d exp %0d", done_cyc, start_cyc + 2); else n_pass++;
    n_chk++; if (o_cpu_rstn !== 1'b1) $display("FAIL zero_release got %b exp 1", o_cpu_rstn); else n_pass++;
  endtask

  task automatic test_clamp();
    int d0 = done_cnt;
    clr_log();
    gen_words(DEPTH);
    start(300);
    stream(DEPTH, 0, 0, 0, 1);
    wait_done(d0);
    model_commit(DEPTH);
    n_chk++; if (wq_addr.size() != DEPTH || wq_diffs(DEPTH) != 0) $display("FAIL clamp_writes got %0d exp %0d", wq_addr.size(), DEPTH); else n_pass++;
    n_chk++; if (wq_addr.size() == 0 || wq_addr[wq_addr.size() - 1] !== 32'h3FC)
      $display("FAIL clamp_last_addr got %h exp 000003fc", (wq_addr.size() != 0) ? wq_addr[wq_addr.size() - 1] : 32'hx); else n_pass++;
    n_chk++; if (done_cnt != d0 + 1) $display("FAIL clamp_done got %0d exp 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_abort();
    clr_log();
    gen_words(3);
    start(10);
    stream(3, 0, 0, 0, 0);
    #1;
    n_chk++; if (o_busy !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", o_busy); else n_pass++;
    rstn = 0; #1;
    n_chk++; if ({o_busy, s_ready, o_cpu_rstn, o_mem_we} !== 4'b0)
      $display("FAIL abort_idle got %b exp 0000", {o_busy, s_ready, o_cpu_rstn, o_mem_we}); else n_pass++;
    model_commit(3);
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk); #3;
    n_chk++; if (wq_addr.size() != 3 || mem_diffs() != 0) $display("FAIL abort_mem got %0d writes %0d diffs exp 3 0", wq_addr.size(), mem_diffs()); else n_pass++;
  endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
  task automatic test_csum_fail();
    int d0 = done_cnt;
    clr_log();
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    start(2);
    stream(2, 0, 1, 0, 2);
    repeat (4) @(negedge clk); #1;
    model_commit(2);
    n_chk++; if (o_err !== 1'b1 || done_cnt != d0) $display("FAIL csum_fail_err got err %b done %0d exp 1 0", o_err, done_cnt - d0); else n_pass++;
    n_chk++; if ({o_busy, o_cpu_rstn, s_ready} !== 3'b0) $display("FAIL csum_fail_idle got %b exp 000", {o_busy, o_cpu_rstn, s_ready}); else n_pass++;
  endtask

  task automatic test_csum_pass();
    int d0 = done_cnt;
    clr_log();
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    start(2);
    stream(2, 0, 1, 0, 1);
    wait_done(d0);
    model_commit(2);
    n_chk++; if (o_err !== 1'b0 || done_cnt != d0 + 1) $display("FAIL csum_pass got err %b done %0d exp 0 1", o_err, done_cnt - d0); else n_pass++;
    n_chk++; if (wq_addr.size() != 2 || mem_diffs() != 0) $display("FAIL csum_pass_mem got %0d writes exp 2", wq_addr.size()); else n_pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_backpressure();
    test_random();
    test_zero_len();
    test_clamp();
    test_abort();
`ifdef IMEM_BOOT_CHECKSUM_EN
    test_csum_fail();
    test_csum_pass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
